opentdc_wb_multi: RTL and testbench
===================================

// Module: opentdc_wb_multi
// PURPOSE
//  Parametrised multi-channel time-to-digital front-end with a Wishbone slave, next generation of
//  opentdc_wb. Timestamps rising edges on NCHAN pad inputs against a free-running coarse counter,
//  holds one capture per channel with overrun flag, and drives a programmable one-shot output pulse
//  with pad output-enable control. Instantiated directly in user_project_wrapper on the wb_clk_i domain.
// PARAMETERS
//  NCHAN      5   number of input channels, 1..16
//  TW         32  coarse time counter / timestamp width, 16..32
//  PULSE_LEN  4   out0_o high time in clocks, 1..255
// PORTS
//  wb_clk_i      in   1      sole clock
//  wb_rst_i      in   1      synchronous reset, active high
//  wbs_stb_i     in   1      WB strobe
//  wbs_cyc_i     in   1      WB cycle
//  wbs_we_i      in   1      WB write enable
//  wbs_sel_i     in   4      WB byte lanes
//  wbs_dat_i     in   32     WB write data
//  wbs_adr_i     in   32     WB address; bits [7:2] decoded
//  wbs_ack_o     out  1      WB acknowledge
//  wbs_dat_o     out  32     WB read data, valid with ack
//  inp_i         in   NCHAN  asynchronous pad inputs
//  rst_time_n_i  in   1      asynchronous pad, low holds time counter at 0
//  out0_o        out  1      one-shot pulse output
//  oen_o         out  1      pad output enable, active low (to io_oeb)
//  irq_o         out  1      OR over channels of (valid & enable)
// BEHAVIOUR
//  Reset: all registers 0; wbs_ack_o=0, wbs_dat_o=0, out0_o=0, oen_o=1, irq_o=0, time=0, disarmed.
//  WB: request = stb&cyc&!ack; ack high exactly the next cycle, one cycle wide; no back-to-back ack.
//   Writes honour wbs_sel_i lanes; unmapped addresses: read 0, write ignored, still acked.
//  Map (adr[7:2]): 0 CTRL rw [NCHAN-1:0] chan enable, [16] out enable, [31] soft time clear (self-clears, reads 0)
//   1 TIME ro current counter (zero-extended)   2 STATUS ro [NCHAN-1:0] valid, [16+NCHAN-1:16] overrun
//   3 OUT_TIME rw pulse target; any write arms the pulse   4+i CAPTURE[i] ro timestamp, i<NCHAN
//  Time: TW-bit counter +1 per clock, wraps 2^TW-1 -> 0. rst_time_n_i via 2-FF sync; synced low or
//   CTRL[31] write -> counter reads 0 next cycle and holds while synced low.
//  Capture: inp_i via 2-FF sync + rising-edge detect (3rd FF). On detected edge of enabled channel:
//   if !valid -> CAPTURE=time in detect cycle, valid=1; if valid -> CAPTURE unchanged, overrun=1.
//   Disabled channel: edges ignored, valid/overrun untouched. Pin edge to valid = 3 clocks.
//  Read of CAPTURE[i] (ack cycle) clears valid[i] and overrun[i]. Same-cycle new edge: read returns old
//   value, new timestamp stored, valid stays 1, overrun 0.
//  Pulse: armed & time==OUT_TIME -> out0_o=1 for exactly PULSE_LEN clocks starting next cycle; arm clears.
//   Re-write of OUT_TIME during pulse: pulse completes, re-arm holds. Time clear does not disarm.
//  oen_o = ~CTRL[16], registered. irq_o registered, one clock after valid change.
//  wb_rst_i mid-transaction: ack suppressed, pulse aborted (out0_o=0 next cycle), all state to reset.
// TESTING
//  Reset, read adr 0/2/4 -> 0; oen_o=1, out0_o=0; each read acked 1 clock after stb, ack 1 cycle wide.
//  CTRL=0x1F, inp_i[2] rises with TIME=100 at sampling -> STATUS bit2=1 at 103, CAPTURE[2]=103, irq_o=1.
//  Second edge on ch2 before read -> CAPTURE[2] unchanged, STATUS bit18=1; read CAPTURE[2] -> STATUS=0.
//  OUT_TIME=500, CTRL[16]=1 -> oen_o=0; out0_o high cycles TIME=501..504 only; no repeat after wrap.
//  TW=16: counter 0xFFFF -> 0x0000; capture at wrap stores 0x0000; rst_time_n_i low 10 clks -> TIME=0.
//  Channel disabled, edges on ch0 -> STATUS bit0 stays 0; wb_rst_i during pulse -> out0_o=0 next cycle.

Source files
------------

// File: rtl/opentdc_wb_multi.sv
// Multi-channel rising-edge timestamper with one-shot pulse output behind a Wishbone slave.
// WB ack one clock after request, no wait states, never back-to-back; pin edge to valid in 3 clocks.
module opentdc_wb_multi #(
   parameter int NCHAN     = 5,
   parameter int TW        = 32,
   parameter int PULSE_LEN = 4
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_dat_i,
   input  logic [31:0]      wbs_adr_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic [NCHAN-1:0] inp_i,
   input  logic             rst_time_n_i,
   output logic             out0_o,
   output logic             oen_o,
   output logic             irq_o
);
   localparam logic [7:0] PLEN_M1 = 8'(PULSE_LEN - 1);

   logic             ack_q;
   logic [31:0]      dat_q;
   logic [NCHAN-1:0] en_q;
   logic             oe_en_q;
   logic             oen_q;
   logic             irq_q;
   logic [TW-1:0]    time_q;
   logic [TW-1:0]    out_time_q;
   logic             armed_q;
   logic             out0_q;
   logic [7:0]       pcnt_q;
   logic [1:0]       rt_sync_q;
   logic [NCHAN-1:0] s1_q, s2_q, s3_q;
   logic [NCHAN-1:0] valid_q, ovr_q;
   logic [TW-1:0]    cap_q [NCHAN];

   logic             req, wr, rd;
   logic [5:0]       idx;
   logic [31:0]      wmask;
   logic [31:0]      rdata;
   logic             time_clr;
   logic [TW-1:0]    time_d;
   logic             pulse_start;
   logic [NCHAN-1:0] hit, rd_clr, en_wd;
   logic             oe_wd;
   logic [TW-1:0]    ot_wd;
   logic             unused_ok;

   assign req   = wbs_stb_i & wbs_cyc_i & ~ack_q;
   assign wr    = req & wbs_we_i;
   assign rd    = req & ~wbs_we_i;
   assign idx   = wbs_adr_i[7:2];
   assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

   assign en_wd = (en_q & ~wmask[NCHAN-1:0]) | (wbs_dat_i[NCHAN-1:0] & wmask[NCHAN-1:0]);
   assign oe_wd = wbs_sel_i[2] ? wbs_dat_i[16] : oe_en_q;
   assign ot_wd = (out_time_q & ~wmask[TW-1:0]) | (wbs_dat_i[TW-1:0] & wmask[TW-1:0]);

   assign time_clr = wr && (idx == 6'd0) && wbs_sel_i[3] && wbs_dat_i[31];
   assign time_d   = (~rt_sync_q[1] | time_clr) ? '0 : time_q + TW'(1);

   // Timestamp is the counter value in the cycle the capture becomes visible.
   assign hit         = s2_q & ~s3_q & en_q;
   assign pulse_start = armed_q & ~out0_q & (time_q == out_time_q);

   assign unused_ok = ^{wbs_adr_i[31:8], wbs_adr_i[1:0], wbs_dat_i, wmask};

   always_comb begin
      rd_clr = '0;
      for (int i = 0; i < NCHAN; i++)
         rd_clr[i] = rd && (idx == 6'(4 + i));
   end

   always_comb begin
      rdata = '0;
      case (idx)
         6'd0: begin
            rdata[NCHAN-1:0] = en_q;
            rdata[16]        = oe_en_q;
         end
         6'd1: rdata = 32'(time_q);
         6'd2: begin
            rdata[NCHAN-1:0]  = valid_q;
            rdata[16 +: NCHAN] = ovr_q;
         end
         6'd3: rdata = 32'(out_time_q);
         default: begin
            for (int i = 0; i < NCHAN; i++)
               if (idx == 6'(4 + i)) rdata = 32'(cap_q[i]);
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q      <= 1'b0;
         dat_q      <= '0;
         en_q       <= '0;
         oe_en_q    <= 1'b0;
         oen_q      <= 1'b1;
         irq_q      <= 1'b0;
         time_q     <= '0;
         out_time_q <= '0;
         armed_q    <= 1'b0;
         out0_q     <= 1'b0;
         pcnt_q     <= '0;
         rt_sync_q  <= '0;
         s1_q       <= '0;
         s2_q       <= '0;
         s3_q       <= '0;
         valid_q    <= '0;
         ovr_q      <= '0;
         for (int i = 0; i < NCHAN; i++) cap_q[i] <= '0;
      end else begin
         ack_q     <= req;
         dat_q     <= rd ? rdata : '0;
         rt_sync_q <= {rt_sync_q[0], rst_time_n_i};
         s1_q      <= inp_i;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         time_q    <= time_d;
         oen_q     <= ~oe_en_q;
         irq_q     <= |(valid_q & en_q);

         if (wr && idx == 6'd0) begin
            en_q    <= en_wd;
            oe_en_q <= oe_wd;
         end

         // A write landing on the start cycle re-arms for the new target.
         if (wr && idx == 6'd3) begin
            out_time_q <= ot_wd;
            armed_q    <= 1'b1;
         end else if (pulse_start) begin
            armed_q <= 1'b0;
         end

         if (pulse_start) begin
            out0_q <= 1'b1;
            pcnt_q <= PLEN_M1;
         end else if (out0_q) begin
            if (pcnt_q == 8'd0) out0_q <= 1'b0;
            else                pcnt_q <= pcnt_q - 8'd1;
         end

         for (int i = 0; i < NCHAN; i++) begin
            if (hit[i] && (!valid_q[i] || rd_clr[i])) begin
               cap_q[i]   <= time_d;
               valid_q[i] <= 1'b1;
               ovr_q[i]   <= 1'b0;
            end else if (hit[i]) begin
               ovr_q[i] <= 1'b1;
            end else if (rd_clr[i]) begin
               valid_q[i] <= 1'b0;
               ovr_q[i]   <= 1'b0;
            end
         end
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign out0_o    = out0_q;
   assign oen_o     = oen_q;
   assign irq_o     = irq_q;

endmodule

// File: tb/tb_opentdc_wb_multi.sv
// Bench for opentdc_wb_multi with TW=16 so the counter wrap is reachable.
module tb_opentdc_wb_multi;
   localparam int NCHAN     = 5;
   localparam int TW        = 16;
   localparam int PULSE_LEN = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]       sel = '0;
   logic [31:0]      dat = '0, adr = '0;
   logic             ack;
   logic [31:0]      rdat;
   logic [NCHAN-1:0] inp = '0;
   logic             rst_time_n = 1'b1;
   logic             out0, oen, irq;

   int errors = 0;
   int checks = 0;

   logic [TW-1:0] mtime;
   logic [1:0]    mrt;
   logic          mack;
   logic [31:0]   rd_exp[$];
   logic [31:0]   cap_exp[$];
   logic [TW-1:0] pulse_exp[$];
   logic [TW-1:0] pulse_obs[$];
   logic [31:0]   got, exp;
   logic          ok;
   logic [TW-1:0] pe, po, tt;

   always #5 clk = ~clk;

   opentdc_wb_multi #(.NCHAN(NCHAN), .TW(TW), .PULSE_LEN(PULSE_LEN)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
      .inp_i(inp), .rst_time_n_i(rst_time_n),
      .out0_o(out0), .oen_o(oen), .irq_o(irq)
   );

   // Reference time counter built from the bus and pad stimulus.
   always @(posedge clk) begin
      if (rst) begin
         mtime <= '0;
         mrt   <= '0;
         mack  <= 1'b0;
      end else begin
         mrt  <= {mrt[0], rst_time_n};
         mack <= stb & cyc & ~mack;
         if (!mrt[1] || (stb && cyc && we && !mack && adr[7:2] == 6'd0 && sel[3] && dat[31]))
            mtime <= '0;
         else
            mtime <= mtime + 1'b1;
      end
   end

   always @(negedge clk) if (out0 === 1'b1) pulse_obs.push_back(mtime);

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   // Request cycle is the cycle in which the task is called.
   task automatic wb_xfer(input logic w, input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r, output logic okay);
      logic a0, a1, a2;
      stb = 1'b1; cyc = 1'b1; we = w; adr = {24'h0, a, 2'b00}; dat = d; sel = s;
      a0 = ack;
      @(posedge clk); #1;
      a1 = ack; r = rdat;
      @(posedge clk); #1;
      a2 = ack;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      okay = !a0 && a1 && !a2;
   endtask

   task automatic wait_time(input logic [TW-1:0] t);
      int n = 0;
      @(negedge clk);
      while (mtime !== t && n < 70000) begin
         @(negedge clk);
         n++;
      end
      if (mtime !== t) begin
         checks++; errors++;
         $display("FAIL wait_time: got=%h exp=%h", mtime, t);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ack !== 1'b0 || rdat !== 32'h0) begin errors++; $display("FAIL rst_wb: ack=%b dat=%h exp 0/0", ack, rdat); end
      checks++; if (oen !== 1'b1) begin errors++; $display("FAIL rst_oen: got=%b exp=1", oen); end
      checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL rst_out0: got=%b exp=0", out0); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got=%b exp=0", irq); end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         rd_exp.push_back(32'h0);
         wb_xfer(1'b0, 6'(2 * k), 32'h0, 4'hF, got, ok);
         exp = rd_exp.pop_front(); checks++;
         if (got !== exp || !ok) begin errors++; $display("FAIL rst_read%0d: got=%h ack_ok=%b exp=%h", 2 * k, got, ok, exp); end
      end
      rd_exp.push_back(32'(mtime));
      wb_xfer(1'b0, 6'd1, 32'h0, 4'hF, got, ok);
      exp = rd_exp.pop_front(); checks++;
      if (got !== exp || !ok) begin errors++; $display("FAIL rst_time: got=%h ack_ok=%b exp=%h", got, ok, exp); end
   endtask

   task automatic test_ctrl_regs();
      wb_xfer(1'b1, 6'd0, 32'h8000_001F, 4'hF, got, ok);
      rd_exp.push_back(32'h1);
      wb_xfer(1'b0, 6'd1, 32'h0, 4'hF, got, ok);
      exp = rd_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL soft_clear_time: got=%h exp=%h", got, exp); end
      wb_xfer(1'b1, 6'd0, 32'hFFFF_FFFF, 4'b0100, got, ok);
      rd_exp.push_back(32'h0001_001F);
      wb_xfer(1'b0, 6'd0, 32'h0, 4'hF, got, ok);
      exp = rd_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL ctrl_lane: got=%h exp=%h", got, exp); end
      checks++; if (oen !== 1'b0) begin errors++; $display("FAIL oen_on: got=%b exp=0", oen); end
      wb_xfer(1'b1, 6'd0, 32'h0, 4'b0100, got, ok);
      @(negedge clk);
      checks++; if (oen !== 1'b1) begin errors++; $display("FAIL oen_off: got=%b exp=1", oen); end
      wb_xfer(1'b1, 6'd63, 32'hFFFF_FFFF, 4'hF, got, ok);
      rd_exp.push_back(32'h0);
      wb_xfer(1'b0, 6'd63, 32'h0, 4'hF, got, ok);
      exp = rd_exp.pop_front(); checks++;
      if (got !== exp || !ok) begin errors++; $display("FAIL unmapped: got=%h ack_ok=%b exp=%h", got, ok, exp); end
   endtask

   task automatic test_capture();
      wait_time(16'd100);
      inp[2] = 1'b1; cap_exp.push_back(32'd103);
      rd_exp.push_back(32'h0);
      wait_time(16'd102);
      wb_xfer(1'b0, 6'd2, 32'h0, 4'hF, got, ok);
      exp = rd_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL status_early: got=%h exp=%h", got, exp); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got=%b exp=1", irq); end
      rd_exp.push_back(32'h4);
      wb_xfer(1'b0, 6'd2, 32'h0, 4'hF, got, ok);
      exp = rd_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL status_valid: got=%h exp=%h", got, exp); end
      inp[2] = 1'b0;
      repeat (3) @(negedge clk);
      inp[2] = 1'b1;
      repeat (4) @(negedge clk);
      rd_exp.push_back(32'h0004_0004);
      wb_xfer(1'b0, 6'd2, 32'h0, 4'hF, got, ok);
      exp = rd_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL status_overrun: got=%h exp=%h", got, exp); end
      wb_xfer(1'b0, 6'd6, 32'h0, 4'hF, got, ok);
      exp = cap_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL capture2: got=%h exp=%h", got, exp); end
      rd_exp.push_back(32'h0);
      wb_xfer(1'b0, 6'd2, 32'h0, 4'hF, got, ok);
      exp = rd_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL status_cleared: got=%h exp=%h", got, exp); end
      @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got=%b exp=0", irq); end
      inp[2] = 1'b0;
   endtask

   task automatic test_collision();
      @(negedge clk);
      tt = mtime + 16'd3; inp[1] = 1'b1; cap_exp.push_back(32'(tt));
      repeat (5) @(negedge clk);
      inp[1] = 1'b0;
      repeat (3) @(negedge clk);
      tt = mtime + 16'd3; inp[1] = 1'b1;
      repeat (2) @(negedge clk);
      wb_xfer(1'b0, 6'd5, 32'h0, 4'hF, got, ok);
      cap_exp.push_back(32'(tt));
      exp = cap_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL collide_old: got=%h exp=%h", got, exp); end
      rd_exp.push_back(32'h2);
      wb_xfer(1'b0, 6'd2, 32'h0, 4'hF, got, ok);
      exp = rd_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL collide_status: got=%h exp=%h", got, exp); end
      wb_xfer(1'b0, 6'd5, 32'h0, 4'hF, got, ok);
      exp = cap_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL collide_new: got=%h exp=%h", got, exp); end
      inp[1] = 1'b0;
   endtask

   task automatic test_disabled();
      wb_xfer(1'b1, 6'd0, 32'h1E, 4'hF, got, ok);
      for (int k = 0; k < 4; k++) begin
         inp[0] = 1'b1; repeat (3) @(negedge clk);
         inp[0] = 1'b0; repeat (3) @(negedge clk);
      end
      rd_exp.push_back(32'h0);
      wb_xfer(1'b0, 6'd2, 32'h0, 4'hF, got, ok);
      exp = rd_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL disabled_status: got=%h exp=%h", got, exp); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL disabled_irq: got=%b exp=0", irq); end
   endtask

   task automatic test_pulse_wrap();
      pulse_obs.delete();
      wb_xfer(1'b1, 6'd0, 32'h0001_001F, 4'hF, got, ok);
      checks++; if (oen !== 1'b0) begin errors++; $display("FAIL pulse_oen: got=%b exp=0", oen); end
      wb_xfer(1'b1, 6'd3, 32'd500, 4'hF, got, ok);
      for (int k = 1; k <= PULSE_LEN; k++) pulse_exp.push_back(TW'(500 + k));
      wait_time(16'd520);
      checks++;
      if (pulse_obs.size() != pulse_exp.size()) begin errors++; $display("FAIL pulse_len: got=%0d exp=%0d", pulse_obs.size(), pulse_exp.size()); end
      while (pulse_exp.size() > 0 && pulse_obs.size() > 0) begin
         pe = pulse_exp.pop_front(); po = pulse_obs.pop_front(); checks++;
         if (po !== pe) begin errors++; $display("FAIL pulse_time: got=%h exp=%h", po, pe); end
      end
      pulse_exp.delete(); pulse_obs.delete();
      wait_time(16'hFFFD);
      inp[3] = 1'b1; cap_exp.push_back(32'h0);
      rd_exp.push_back(32'h0000_FFFE);
      wait_time(16'hFFFE);
      wb_xfer(1'b0, 6'd1, 32'h0, 4'hF, got, ok);
      exp = rd_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL time_ffff: got=%h exp=%h", got, exp); end
      rd_exp.push_back(32'h0);
      wb_xfer(1'b0, 6'd1, 32'h0, 4'hF, got, ok);
      exp = rd_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL time_wrap: got=%h exp=%h", got, exp); end
      wb_xfer(1'b0, 6'd7, 32'h0, 4'hF, got, ok);
      exp = cap_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL capture_wrap: got=%h exp=%h", got, exp); end
      inp[3] = 1'b0;
      wait_time(16'd520);
      checks++;
      if (pulse_obs.size() != 0) begin errors++; $display("FAIL pulse_repeat: got=%0d exp=0", pulse_obs.size()); end
   endtask

   task automatic test_rearm();
      pulse_obs.delete();
      wb_xfer(1'b1, 6'd3, 32'd50, 4'hF, got, ok);
      wb_xfer(1'b1, 6'd0, 32'h8001_001F, 4'hF, got, ok);
      for (int k = 1; k <= PULSE_LEN; k++) pulse_exp.push_back(TW'(50 + k));
      wait_time(16'd52);
      wb_xfer(1'b1, 6'd3, 32'd80, 4'hF, got, ok);
      for (int k = 1; k <= PULSE_LEN; k++) pulse_exp.push_back(TW'(80 + k));
      wait_time(16'd100);
      checks++;
      if (pulse_obs.size() != pulse_exp.size()) begin errors++; $display("FAIL rearm_len: got=%0d exp=%0d", pulse_obs.size(), pulse_exp.size()); end
      while (pulse_exp.size() > 0 && pulse_obs.size() > 0) begin
         pe = pulse_exp.pop_front(); po = pulse_obs.pop_front(); checks++;
         if (po !== pe) begin errors++; $display("FAIL rearm_time: got=%h exp=%h", po, pe); end
      end
      pulse_exp.delete(); pulse_obs.delete();
   endtask

   task automatic test_rst_time();
      @(negedge clk);
      rst_time_n = 1'b0;
      repeat (4) @(negedge clk);
      rd_exp.push_back(32'h0);
      wb_xfer(1'b0, 6'd1, 32'h0, 4'hF, got, ok);
      exp = rd_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL time_hold: got=%h exp=%h", got, exp); end
      repeat (5) @(negedge clk);
      rst_time_n = 1'b1;
      repeat (3) @(negedge clk);
      rd_exp.push_back(32'h1);
      wb_xfer(1'b0, 6'd1, 32'h0, 4'hF, got, ok);
      exp = rd_exp.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL time_release: got=%h exp=%h", got, exp); end
   endtask

   task automatic test_rst_pulse();
      pulse_obs.delete();
      tt = mtime + 16'd20;
      wb_xfer(1'b1, 6'd3, 32'(tt), 4'hF, got, ok);
      pulse_exp.push_back(tt + 16'd1); pulse_exp.push_back(tt + 16'd2);
      wait_time(tt + 16'd2);
      rst = 1'b1; stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h0;
      @(posedge clk); #1;
      checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL rst_abort_out0: got=%b exp=0", out0); end
      @(posedge clk); #1;
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack_suppress: got=%b exp=0", ack); end
      stb = 1'b0; cyc = 1'b0;
      @(negedge clk); rst = 1'b0;
      checks++;
      if (pulse_obs.size() != pulse_exp.size()) begin errors++; $display("FAIL rst_pulse_len: got=%0d exp=%0d", pulse_obs.size(), pulse_exp.size()); end
      while (pulse_exp.size() > 0 && pulse_obs.size() > 0) begin
         pe = pulse_exp.pop_front(); po = pulse_obs.pop_front(); checks++;
         if (po !== pe) begin errors++; $display("FAIL rst_pulse_time: got=%h exp=%h", po, pe); end
      end
      pulse_exp.delete();
      checks++; if (oen !== 1'b1) begin errors++; $display("FAIL rst_oen_after: got=%b exp=1", oen); end
      @(negedge clk);
      rd_exp.push_back(32'h0);
      wb_xfer(1'b0, 6'd0, 32'h0, 4'hF, got, ok);
      exp = rd_exp.pop_front(); checks++;
      if (got !== exp || !ok) begin errors++; $display("FAIL rst_ctrl_after: got=%h ack_ok=%b exp=%h", got, ok, exp); end
   endtask

   initial begin
      test_reset();
      test_ctrl_regs();
      test_capture();
      test_collision();
      test_disabled();
      test_pulse_wrap();
      test_rearm();
      test_rst_time();
      test_rst_pulse();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
